// File: rtl/cmp_sort_pkg.sv
// rtl/cmp_sort_pkg.sv - shared state encoding and pointer sizing for the sort controller
package cmp_sort_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Pointer width for a buffer of `depth` entries; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/cmp_sort_ctrl_cmp_signed.sv
// rtl/cmp_sort_ctrl_cmp_signed.sv - combinational two's-complement magnitude comparator
module cmp_signed #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  // Differing sign bits settle the order; otherwise the low bits compare unsigned.
  always_comb begin
    gt_o = 1'b0;
    eq_o = 1'b0;
    lt_o = 1'b0;
    if (a_i[WIDTH-1] != b_i[WIDTH-1]) begin
      lt_o = a_i[WIDTH-1];
      gt_o = b_i[WIDTH-1];
    end else if (a_i[WIDTH-2:0] > b_i[WIDTH-2:0]) begin
      gt_o = 1'b1;
    end else if (a_i[WIDTH-2:0] < b_i[WIDTH-2:0]) begin
      lt_o = 1'b1;
    end else begin
      eq_o = 1'b1;
    end
  end

endmodule

// File: rtl/cmp_sort_ctrl.sv
// rtl/cmp_sort_ctrl.sv - load / bubble-sort / drain controller around one shared comparator
module cmp_sort_ctrl
  import cmp_sort_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int PW = ptr_width(DEPTH);

  state_e           state_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    idx_q;
  logic [PW-1:0]    pass_q;
  logic             swapped_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    idx_nx;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             do_swap;
  logic             pass_swapped;

  assign idx_nx = idx_q + PW'(1);
  assign cmp_a  = mem_q[idx_q];
  assign cmp_b  = mem_q[idx_nx];

  cmp_signed #(.WIDTH(WIDTH)) u_cmp (
    .a_i  (cmp_a),
    .b_i  (cmp_b),
    .gt_o (cmp_gt),
    .eq_o (cmp_eq),
    .lt_o (cmp_lt)
  );

  // Swap only on a strict greater-than so equal keys keep their order.
  assign do_swap      = cmp_gt && !(cmp_eq || cmp_lt);
  // Includes the swap made on the last compare of the pass, which the register has not seen yet.
  assign pass_swapped = swapped_q || do_swap;

  // Stream-side outputs are pure decodes of the registered state and pointers.
  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_SORT);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = (state_q == ST_DRAIN) ? mem_q[rd_ptr_q] : '0;
  assign out_last  = (state_q == ST_DRAIN) && (rd_ptr_q == PW'(DEPTH - 1));

  // Controller FSM: capture DEPTH words, bubble-sort one pair per cycle, then stream out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      swapped_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            mem_q[wr_ptr_q] <= in_data;
            if (wr_ptr_q == PW'(DEPTH - 1)) begin
              wr_ptr_q  <= '0;
              idx_q     <= '0;
              pass_q    <= '0;
              swapped_q <= 1'b0;
              state_q   <= ST_SORT;
            end else begin
              wr_ptr_q <= wr_ptr_q + PW'(1);
            end
          end
        end
        ST_SORT: begin
          if (do_swap) begin
            mem_q[idx_q]  <= cmp_b;
            mem_q[idx_nx] <= cmp_a;
          end
          if (idx_q < PW'(DEPTH - 2)) begin
            idx_q     <= idx_nx;
            swapped_q <= pass_swapped;
          end else if (!pass_swapped || (pass_q == PW'(DEPTH - 2))) begin
            rd_ptr_q  <= '0;
            swapped_q <= 1'b0;
            state_q   <= ST_DRAIN;
          end else begin
            pass_q    <= pass_q + PW'(1);
            idx_q     <= '0;
            swapped_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (rd_ptr_q == PW'(DEPTH - 1)) begin
              rd_ptr_q <= '0;
              state_q  <= ST_LOAD;
            end else begin
              rd_ptr_q <= rd_ptr_q + PW'(1);
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb/tb_cmp_sort_ctrl.sv - scoreboard bench for the sort controller
module tb_cmp_sort_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;

  int n_checks;
  int n_fail;

  logic signed [3:0] sb_q[$];

  cmp_sort_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push the ascending order of w into the scoreboard, then feed w in (optionally with idle gaps).
  task automatic load_job(input logic signed [3:0] w[4], input bit stall);
    logic signed [3:0] s[4];
    logic signed [3:0] t;
    int j;
    for (int i = 0; i < 4; i++) s[i] = w[i];
    for (int i = 1; i < 4; i++) begin
      t = s[i];
      j = i - 1;
      while (j >= 0 && s[j] > t) begin
        s[j+1] = s[j];
        j--;
      end
      s[j+1] = t;
    end
    for (int i = 0; i < 4; i++) sb_q.push_back(s[i]);
    for (int i = 0; i < 4; i++) begin
      if (stall) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'd6;
        @(posedge clk);
      end
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_in_ready actual=%b required=1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = w[i];
      @(posedge clk);
    end
  endtask

  // Count SORT cycles while offering junk input that must be ignored.
  task automatic wait_sort(input int exp_cycles);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'd5;
    while (busy === 1'b1 && n < 50) begin
      n++;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL sort_in_ready actual=%b required=0", in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (exp_cycles >= 0) begin
      n_checks++;
      if (n != exp_cycles) begin
        n_fail++;
        $display("FAIL sort_cycles actual=%0d required=%0d", n, exp_cycles);
      end
    end
  endtask

  // Accept four words against the scoreboard; bp holds out_ready low for 5 cycles after the first word.
  task automatic drain(input bit bp);
    int k;
    int guard;
    int held;
    logic signed [3:0] exp;
    k = 0;
    guard = 0;
    held = 0;
    while (k < 4 && guard < 100) begin
      if (guard > 0) @(negedge clk);
      guard++;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_in_ready actual=%b required=0", in_ready);
      end
      if (bp && k == 1 && held < 5) begin
        out_ready = 1'b0;
        held++;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== sb_q[0]) begin
          n_fail++;
          $display("FAIL hold_stable actual=%b/%0d required=1/%0d", out_valid, $signed(out_data), sb_q[0]);
        end
        @(posedge clk);
        continue;
      end
      out_ready = 1'b1;
      if (out_valid === 1'b1) begin
        exp = sb_q.pop_front();
        n_checks++;
        if (out_data !== exp) begin
          n_fail++;
          $display("FAIL drain_data[%0d] actual=%0d required=%0d", k, $signed(out_data), exp);
        end
        n_checks++;
        if (out_last !== (k == 3)) begin
          n_fail++;
          $display("FAIL drain_last[%0d] actual=%b required=%b", k, out_last, (k == 3));
        end
        k++;
      end
      @(posedge clk);
    end
    n_checks++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL drain_timeout actual=%0d words required=4", k);
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_load actual=%b/%b required=1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_data !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs actual=%b%b%b%b/%0d required=1000/0", in_ready, out_valid, out_last, busy, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_sort;
    load_job('{4'sd3, 4'sd1, 4'sd2, 4'sd0}, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_data !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_sort actual=%b%b%b%b/%0d required=1000/0", in_ready, out_valid, out_last, busy, out_data);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    load_job('{4'sd1, 4'sd2, 4'sd3, 4'sd4}, 1'b0);
    wait_sort(3);
    drain(1'b0);
  endtask

  task automatic test_sorted;
    load_job('{-4'sd8, -4'sd1, 4'sd0, 4'sd7}, 1'b0);
    wait_sort(3);
    drain(1'b0);
  endtask

  task automatic test_reverse;
    load_job('{4'sd7, 4'sd3, -4'sd2, -4'sd8}, 1'b0);
    wait_sort(9);
    drain(1'b0);
  endtask

  task automatic test_dups;
    load_job('{-4'sd1, 4'sd7, -4'sd1, -4'sd8}, 1'b0);
    wait_sort(9);
    drain(1'b0);
  endtask

  task automatic test_backpressure;
    load_job('{4'sd2, -4'sd5, 4'sd6, -4'sd1}, 1'b0);
    wait_sort(-1);
    drain(1'b1);
  endtask

  task automatic test_input_stalls;
    load_job('{4'sd5, -4'sd3, 4'sd0, -4'sd3}, 1'b1);
    wait_sort(9);
    drain(1'b0);
  endtask

  task automatic test_back_to_back;
    load_job('{4'sd0, -4'sd7, 4'sd4, 4'sd1}, 1'b0);
    wait_sort(-1);
    drain(1'b0);
    load_job('{-4'sd6, -4'sd6, 4'sd3, -4'sd2}, 1'b0);
    wait_sort(-1);
    drain(1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_reset_mid_sort();
    test_sorted();
    test_reverse();
    test_dups();
    test_backpressure();
    test_input_stalls();
    test_back_to_back();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
